// File: rtl/mips_memory_port_arbiter.sv
// Arbitrates fetch vs data onto one word memory; optional MIPS_MEMORY_PORT_ARBITER_FETCH_BUFFER_EN adds a one-entry fetch buffer.
// Latency: store 2, load/fetch LATENCY+2 cycles from grant, nop/misaligned 1; stall holds the pipeline until the ready pulse.
module mips_memory_port_arbiter #(
    parameter int LATENCY       = 1,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetchRequest,
    input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
    output logic                     fetchReady,
    output logic [31:0]              fetchData,
    input  logic                     dataRequest,
    input  logic                     dataWrite,
    input  logic [1:0]               dataByteEnable,
    input  logic                     dataExtend,
    input  logic [ADDRESS_WIDTH-1:0] dataAddress,
    input  logic [31:0]              dataWriteData,
    output logic                     dataReady,
    output logic [31:0]              dataReadData,
    output logic                     misaligned,
    output logic                     memRequest,
    output logic                     memWriteEnable,
    output logic [ADDRESS_WIDTH-3:0] memAddress,
    output logic [3:0]               memByteMask,
    output logic [31:0]              memWriteData,
    input  logic [31:0]              memReadData,
    output logic                     stall
);
    typedef enum logic [1:0] {IDLE, READ_WAIT, DONE} state_t;

    localparam logic       GRANT_FETCH = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;
    localparam logic [2:0] LAT         = 3'(LATENCY);

    state_t      state;
    logic        last_grant;
    logic [2:0]  lat_cnt;
    logic        owner_data;
    logic        acc_write;
    logic        acc_ext;
    logic [1:0]  acc_be;
    logic [1:0]  acc_lane;

    logic        data_nop;
    logic        data_mis;
    logic        data_wins;
    logic        fetch_wins;
    logic        fetch_hit;
    logic        read_done;
    logic [3:0]  data_mask;
    logic [31:0] store_data;
    logic [31:0] read_shifted;
    logic [31:0] load_result;
    logic [31:0] buf_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^fetchAddress[1:0];

    assign data_nop   = (dataByteEnable == 2'b00);
    assign data_mis   = ((dataByteEnable == 2'b10) && dataAddress[0]) ||
                        ((dataByteEnable == 2'b11) && (dataAddress[1:0] != 2'b00));
    // On contention the requester not served last time goes first.
    assign data_wins  = dataRequest && (!fetchRequest || (last_grant == GRANT_FETCH));
    assign fetch_wins = fetchRequest && !data_wins;
    assign read_done  = (state == READ_WAIT) && !acc_write && (lat_cnt == LAT);

    assign stall = (fetchRequest & ~fetchReady) | (dataRequest & ~dataReady);

    always_comb begin
        data_mask  = 4'b1111;
        store_data = dataWriteData;
        case (dataByteEnable)
            2'b01: begin
                data_mask  = 4'b0001 << dataAddress[1:0];
                store_data = {4{dataWriteData[7:0]}};
            end
            2'b10: begin
                data_mask  = 4'b0011 << dataAddress[1:0];
                store_data = {2{dataWriteData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        read_shifted = memReadData >> {acc_lane, 3'b000};
        load_result  = memReadData;
        case (acc_be)
            2'b01: load_result = acc_ext ? {24'd0, read_shifted[7:0]}
                                         : {{24{read_shifted[7]}}, read_shifted[7:0]};
            2'b10: load_result = acc_ext ? {16'd0, read_shifted[15:0]}
                                         : {{16{read_shifted[15]}}, read_shifted[15:0]};
            default: ;
        endcase
    end

`ifdef MIPS_MEMORY_PORT_ARBITER_FETCH_BUFFER_EN
    logic                     buf_valid;
    logic [ADDRESS_WIDTH-3:0] buf_addr;

    assign fetch_hit = buf_valid && (buf_addr == fetchAddress[ADDRESS_WIDTH-1:2]);

    // memAddress still holds the fetch word address while the read is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (read_done && !owner_data) begin
            buf_valid <= 1'b1;
            buf_addr  <= memAddress;
            buf_data  <= memReadData;
        end else if ((state == IDLE) && data_wins && dataWrite && !data_nop && !data_mis &&
                     (buf_addr == dataAddress[ADDRESS_WIDTH-1:2])) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign fetch_hit = 1'b0;
    assign buf_data  = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= GRANT_FETCH;
            lat_cnt        <= '0;
            owner_data     <= 1'b0;
            acc_write      <= 1'b0;
            acc_ext        <= 1'b0;
            acc_be         <= '0;
            acc_lane       <= '0;
            fetchReady     <= 1'b0;
            fetchData      <= '0;
            dataReady      <= 1'b0;
            dataReadData   <= '0;
            misaligned     <= 1'b0;
            memRequest     <= 1'b0;
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memByteMask    <= '0;
            memWriteData   <= '0;
        end else begin
            memRequest     <= 1'b0;
            memWriteEnable <= 1'b0;
            fetchReady     <= 1'b0;
            dataReady      <= 1'b0;
            misaligned     <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_wins) begin
                        last_grant <= GRANT_DATA;
                        if (data_nop || data_mis) begin
                            dataReady    <= 1'b1;
                            misaligned   <= data_mis;
                            dataReadData <= '0;
                            state        <= DONE;
                        end else begin
                            memRequest     <= 1'b1;
                            memWriteEnable <= dataWrite;
                            memAddress     <= dataAddress[ADDRESS_WIDTH-1:2];
                            memByteMask    <= data_mask;
                            memWriteData   <= store_data;
                            owner_data     <= 1'b1;
                            acc_write      <= dataWrite;
                            acc_be         <= dataByteEnable;
                            acc_ext        <= dataExtend;
                            acc_lane       <= dataAddress[1:0];
                            lat_cnt        <= '0;
                            state          <= READ_WAIT;
                        end
                    end else if (fetch_wins) begin
                        if (fetch_hit) begin
                            fetchReady <= 1'b1;
                            fetchData  <= buf_data;
                            state      <= DONE;
                        end else begin
                            last_grant  <= GRANT_FETCH;
                            memRequest  <= 1'b1;
                            memAddress  <= fetchAddress[ADDRESS_WIDTH-1:2];
                            memByteMask <= 4'b1111;
                            owner_data  <= 1'b0;
                            acc_write   <= 1'b0;
                            lat_cnt     <= '0;
                            state       <= READ_WAIT;
                        end
                    end
                end
                // A store uses this state only for its single strobe cycle.
                READ_WAIT: begin
                    if (acc_write) begin
                        dataReady <= 1'b1;
                        state     <= DONE;
                    end else if (lat_cnt == LAT) begin
                        if (owner_data) begin
                            dataReady    <= 1'b1;
                            dataReadData <= load_result;
                        end else begin
                            fetchReady <= 1'b1;
                            fetchData  <= memReadData;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_memory_port_arbiter.sv
// Bench for mips_memory_port_arbiter: vector table plus scoreboard, with a LATENCY=3 instance for reset-in-flight.
module tb_mips_memory_port_arbiter;
    localparam int LAT = 1;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        fetchRequest, fetchReady, dataRequest, dataWrite, dataExtend, dataReady, misaligned;
    logic [31:0] fetchAddress, dataAddress, fetchData, dataWriteData, dataReadData;
    logic [1:0]  dataByteEnable;
    logic        memRequest, memWriteEnable, stall;
    logic [29:0] memAddress;
    logic [3:0]  memByteMask;
    logic [31:0] memWriteData, memReadData;

    logic        reset3, f3_req, f3_rdy, d3_req, d3_wr, d3_ext, d3_rdy, d3_mis;
    logic [31:0] f3_addr, f3_dat, d3_addr, d3_wdat, d3_rdat;
    logic [1:0]  d3_be;
    logic        m3_req, m3_we, stall3;
    logic [29:0] m3_addr;
    logic [3:0]  m3_mask;
    logic [31:0] m3_wdat, m3_rdat;

    mips_memory_port_arbiter #(.LATENCY(LAT), .ADDRESS_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
        .fetchReady(fetchReady), .fetchData(fetchData),
        .dataRequest(dataRequest), .dataWrite(dataWrite), .dataByteEnable(dataByteEnable),
        .dataExtend(dataExtend), .dataAddress(dataAddress), .dataWriteData(dataWriteData),
        .dataReady(dataReady), .dataReadData(dataReadData), .misaligned(misaligned),
        .memRequest(memRequest), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
        .memByteMask(memByteMask), .memWriteData(memWriteData), .memReadData(memReadData),
        .stall(stall));

    mips_memory_port_arbiter #(.LATENCY(3), .ADDRESS_WIDTH(32)) dut3 (
        .clock(clock), .reset(reset3),
        .fetchRequest(f3_req), .fetchAddress(f3_addr),
        .fetchReady(f3_rdy), .fetchData(f3_dat),
        .dataRequest(d3_req), .dataWrite(d3_wr), .dataByteEnable(d3_be),
        .dataExtend(d3_ext), .dataAddress(d3_addr), .dataWriteData(d3_wdat),
        .dataReady(d3_rdy), .dataReadData(d3_rdat), .misaligned(d3_mis),
        .memRequest(m3_req), .memWriteEnable(m3_we), .memAddress(m3_addr),
        .memByteMask(m3_mask), .memWriteData(m3_wdat), .memReadData(m3_rdat),
        .stall(stall3));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Synchronous memory model: read data appears the cycle after the strobe and is held.
    logic [31:0] mem [0:255];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]      <= 32'h8001_1234;
            mem[4]      <= 32'h1122_3344;
            mem[12]     <= 32'h0BAD_F00D;
            mem[8'h40]  <= 32'hDEAD_BEEF;
            memReadData <= 32'h0;
        end else if (memRequest) begin
            if (memWriteEnable)
                mem[memAddress[7:0]] <= merge(mem[memAddress[7:0]], memWriteData, memByteMask);
            else
                memReadData <= mem[memAddress[7:0]];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        chk;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] fq[$];

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (dataReady) begin
            if (sbq.size() == 0) begin
                check("sb_data_unexpected", dataReady, 1'b0);
            end else begin
                e = sbq.pop_front();
                if (e.chk) check("sb_rdata", dataReadData, e.rdata);
                check("sb_misaligned", misaligned, e.mis);
            end
        end
        if (fetchReady) begin
            if (fq.size() == 0) check("sb_fetch_unexpected", fetchReady, 1'b0);
            else                check("sb_fetch", fetchData, fq.pop_front());
        end
    end

    typedef struct {
        logic        write;
        logic [1:0]  be;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        mis;
        logic        chk;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [1:0] be, input logic ext,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask,
                                input logic [31:0] ewd, input logic [31:0] erd, input logic mis);
        vec_t v;
        v.write = wr; v.be = be; v.ext = ext; v.addr = addr; v.wdata = wd; v.mask = mask;
        v.exp_wdata = ewd; v.exp_rdata = erd; v.mis = mis;
        v.chk = !wr || mis;
        return v;
    endfunction

    task automatic do_data(input vec_t v);
        exp_t e;
        int   n, exp_lat;
        bit   saw_req, done;
        logic exp_req;
        e.rdata = v.exp_rdata; e.mis = v.mis; e.chk = v.chk;
        sbq.push_back(e);
        exp_req = !(v.mis || v.be == 2'b00);
        exp_lat = !exp_req ? 1 : (v.write ? 2 : 2 + LAT);
        @(negedge clock);
        dataWrite = v.write; dataByteEnable = v.be; dataExtend = v.ext;
        dataAddress = v.addr; dataWriteData = v.wdata; dataRequest = 1'b1;
        n = 0; saw_req = 0; done = 0;
        while (!done && n < 20) begin
            @(posedge clock); #1; n++;
            if (memRequest) begin
                saw_req = 1;
                check("vec_mask", memByteMask, v.mask);
                check("vec_we", memWriteEnable, v.write);
                check("vec_addr", memAddress, v.addr[31:2]);
                if (v.write) check("vec_wdata", memWriteData, v.exp_wdata);
            end
            if (dataReady) begin
                done = 1;
                check("vec_latency", n, exp_lat);
            end
        end
        check("vec_done", done, 1'b1);
        if (!done) void'(sbq.pop_back());
        check("vec_memreq", saw_req, exp_req);
        dataRequest = 1'b0;
        @(posedge clock); #1;
    endtask

    vec_t vecs[17];

    initial begin
        int   n, k;
        bit   got;
        logic is_data, exp_data;

        vecs[0]  = mk(1, 2'b01, 0, 32'h203, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0);
        vecs[1]  = mk(0, 2'b01, 1, 32'h203, 32'h0, 4'b1000, 32'h0, 32'h0000_00A5, 0);
        vecs[2]  = mk(0, 2'b01, 0, 32'h203, 32'h0, 4'b1000, 32'h0, 32'hFFFF_FFA5, 0);
        vecs[3]  = mk(0, 2'b10, 0, 32'h002, 32'h0, 4'b1100, 32'h0, 32'hFFFF_8001, 0);
        vecs[4]  = mk(0, 2'b10, 1, 32'h002, 32'h0, 4'b1100, 32'h0, 32'h0000_8001, 0);
        vecs[5]  = mk(0, 2'b11, 0, 32'h006, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        vecs[6]  = mk(0, 2'b10, 0, 32'h001, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        vecs[7]  = mk(1, 2'b10, 0, 32'h012, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0);
        vecs[8]  = mk(0, 2'b11, 0, 32'h010, 32'h0, 4'b1111, 32'h0, 32'hBEEF_3344, 0);
        vecs[9]  = mk(1, 2'b11, 0, 32'h020, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);
        vecs[10] = mk(0, 2'b01, 0, 32'h021, 32'h0, 4'b0010, 32'h0, 32'hFFFF_FFF0, 0);
        vecs[11] = mk(0, 2'b00, 0, 32'h040, 32'h0, 4'b0000, 32'h0, 32'h0, 0);
        vecs[12] = mk(0, 2'b10, 0, 32'h022, 32'h0, 4'b1100, 32'h0, 32'hFFFF_CAFE, 0);
        vecs[13] = mk(0, 2'b01, 1, 32'h020, 32'h0, 4'b0001, 32'h0, 32'h0000_000D, 0);
        vecs[14] = mk(1, 2'b01, 0, 32'h001, 32'h1234_5677, 4'b0010, 32'h7777_7777, 32'h0, 0);
        vecs[15] = mk(0, 2'b10, 1, 32'h000, 32'h0, 4'b0011, 32'h0, 32'h0000_7734, 0);
        vecs[16] = mk(1, 2'b10, 0, 32'h013, 32'h0000_1111, 4'b0000, 32'h0, 32'h0, 1);

        reset = 1'b1; fetchRequest = 0; fetchAddress = 0; dataRequest = 0; dataWrite = 0;
        dataByteEnable = 0; dataExtend = 0; dataAddress = 0; dataWriteData = 0;
        reset3 = 1'b1; f3_req = 0; f3_addr = 32'h100; d3_req = 0; d3_wr = 0; d3_be = 0;
        d3_ext = 0; d3_addr = 0; d3_wdat = 0; m3_rdat = 32'h5A5A_1234;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {fetchReady, dataReady, misaligned, memRequest, memWriteEnable}, 0);
        check("rst_fetchData", fetchData, 0);
        check("rst_dataReadData", dataReadData, 0);
        check("rst_memAddress", memAddress, 0);
        check("rst_memByteMask", memByteMask, 0);
        check("rst_memWriteData", memWriteData, 0);
        @(negedge clock); reset = 1'b0;

        // Single fetch, cycle by cycle
        @(negedge clock);
        fq.push_back(32'hDEAD_BEEF);
        fetchAddress = 32'h100; fetchRequest = 1'b1;
        #1 check("f_stall_c0", stall, 1);
        @(posedge clock); #1;
        check("f_memreq_c1", memRequest, 1);
        check("f_addr_c1", memAddress, 30'h40);
        check("f_mask_c1", memByteMask, 4'b1111);
        check("f_we_c1", memWriteEnable, 0);
        check("f_stall_c1", stall, 1);
        @(posedge clock); #1;
        check("f_memreq_c2", memRequest, 0);
        check("f_stall_c2", stall, 1);
        check("f_ready_c2", fetchReady, 0);
        @(posedge clock); #1;
        check("f_ready_c3", fetchReady, 1);
        check("f_data_c3", fetchData, 32'hDEAD_BEEF);
        check("f_stall_c3", stall, 0);
        fetchRequest = 1'b0;
        @(posedge clock); #1;
        check("f_ready_c4", fetchReady, 0);
        check("f_data_held", fetchData, 32'hDEAD_BEEF);

        // Both requesters held from reset: grants alternate starting with data
        @(negedge clock);
        reset = 1'b1;
        fetchAddress = 32'h100; dataAddress = 32'h30; dataWrite = 0; dataByteEnable = 2'b11;
        fetchRequest = 1'b1; dataRequest = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        k = 0; n = 0;
        while (k < 6 && n < 80) begin
            @(posedge clock); #1; n++;
            if (memRequest) begin
                is_data  = (memAddress == 30'hC);
                exp_data = (k % 2 == 0);
                check("arb_grant", is_data, exp_data);
                if (is_data) sbq.push_back('{32'h0BAD_F00D, 1'b0, 1'b1});
                else         fq.push_back(32'hDEAD_BEEF);
                k++;
            end
        end
        check("arb_count", k, 6);
        @(negedge clock); fetchRequest = 1'b0; dataRequest = 1'b0;
        repeat (8) @(posedge clock);
        #1;

        // Request dropped right after grant still completes
        sbq.push_back('{32'h1122_3344, 1'b0, 1'b1});
        @(negedge clock);
        dataAddress = 32'h10; dataByteEnable = 2'b11; dataWrite = 0; dataRequest = 1'b1;
        @(posedge clock);
        @(negedge clock); dataRequest = 1'b0;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(posedge clock); #1; n++;
            if (dataReady) got = 1;
        end
        check("drop_ready", got, 1);
        @(posedge clock); #1;

        for (int i = 0; i < 17; i++) do_data(vecs[i]);

        // LATENCY=3: reset while the read is outstanding, then a fresh fetch
        @(negedge clock); reset3 = 1'b0; f3_req = 1'b1;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(posedge clock); #1; n++;
            if (m3_req) got = 1;
        end
        check("l3_first_req", got, 1);
        @(posedge clock); #1;
        check("l3_no_ready_wait", f3_rdy, 0);
        @(negedge clock); reset3 = 1'b1;
        @(posedge clock); #1;
        check("l3_rst_ready", {f3_rdy, d3_rdy, d3_mis, m3_req, m3_we}, 0);
        check("l3_rst_addr", m3_addr, 0);
        check("l3_rst_mask", m3_mask, 0);
        check("l3_rst_fdata", f3_dat, 0);
        @(negedge clock); reset3 = 1'b0;
        n = 0; got = 0; k = 0;
        while (!got && n < 20) begin
            @(posedge clock); #1; n++;
            if (m3_req && k == 0) k = n;
            if (f3_rdy) got = 1;
        end
        check("l3_req_cycle", k, 1);
        check("l3_ready_cycle", n, 5);
        check("l3_fetch_data", f3_dat, 32'h5A5A_1234);
        f3_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        check("sb_data_left", sbq.size(), 0);
        check("sb_fetch_left", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mips_memory_port_arbiter.md
Name: mips_memory_port_arbiter

Overview:
Shares one single-port, word-organised memory between instruction fetch and the MEM-stage data access. It arbitrates requests and sequences each access through a fixed read latency. It also produces byte-lane masks, replicates store data, extracts and extends load data, and raises pipeline stall. It sits downstream of the memory control-signal generator: it consumes write-enable, byte-enable and byte-extend, and drives the memory macro.

Parameters:
LATENCY, 1, memory read latency in cycles from the memRequest cycle to valid memReadData (legal range 1..7)
ADDRESS_WIDTH, 32, byte address width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
fetchRequest  input  1  level; held until fetchReady
fetchAddress  input  ADDRESS_WIDTH  byte address; bits [1:0] ignored
fetchReady  output  1  one-cycle pulse: fetchData valid
fetchData  output  32  fetched word; held until next fetchReady
dataRequest  input  1  level; held until dataReady
dataWrite  input  1  1=store, 0=load
dataByteEnable  input  2  00 None, 01 Byte, 10 Half, 11 Word
dataExtend  input  1  0 signed, 1 unsigned (loads only)
dataAddress  input  ADDRESS_WIDTH  byte address
dataWriteData  input  32  store data, right-justified
dataReady  output  1  one-cycle pulse: access complete
dataReadData  output  32  extended load result; held until next dataReady
misaligned  output  1  valid with dataReady; access was suppressed
memRequest  output  1  one-cycle access strobe
memWriteEnable  output  1  qualifies memRequest
memAddress  output  ADDRESS_WIDTH-2  word address
memByteMask  output  4  byte lanes; bit i = bits [8i+7:8i]
memWriteData  output  32  lane-replicated store data
memReadData  input  32  memory read word
stall  output  1  combinational: (fetchRequest & ~fetchReady) | (dataRequest & ~dataReady)

Behaviour:
- Reset: state IDLE; lastGrant=FETCH. All registered outputs are 0: fetchReady, dataReady, fetchData, dataReadData, misaligned, memRequest, memWriteEnable, memAddress, memByteMask, memWriteData. The latency counter is cleared. Reset mid-access abandons the access; no ready pulse is produced.
- States: IDLE, READ_WAIT, DONE. All memory outputs are registered.
- IDLE grant. A data request with dataByteEnable=None completes immediately: dataReady fires next cycle, readData=0, no memory access. If only one requester is pending, it wins. If both are pending, the one not named by lastGrant wins. lastGrant updates on every grant.
- Misalignment: Half with addr[0]=1, or Word with addr[1:0]!=0. No memRequest is issued; dataReady and misaligned pulse in the next cycle; dataReadData=0.
- Store grant: memRequest=1 and memWriteEnable=1 for one cycle, then DONE. dataReady pulses the cycle after memRequest, so latency is 2 cycles from the grant edge.
- Load/fetch grant: memRequest=1 for one cycle, then READ_WAIT. The counter counts LATENCY cycles; memReadData is captured on the last one, then DONE. In DONE, the ready pulse is asserted with the data for exactly one cycle, then IDLE. Requests sampled in DONE are ignored; re-arbitration occurs in IDLE.
- Masks (little-endian, lane = addr[1:0]): Byte 4'b0001<<lane; Half 4'b0011<<lane; Word 4'b1111. Fetch always uses 4'b1111.
- Store data: Byte is {4{d[7:0]}}; Half is {2{d[15:0]}}; Word is d.
- Load data: Byte selects lane byte; Half selects bytes lane..lane+1. Extension is sign or zero per dataExtend captured at grant.
- Request dropped while its access is in flight: the access completes and the ready pulse is still emitted.

Optional Feature:
MIPS_MEMORY_PORT_ARBITER_FETCH_BUFFER_EN
- With: a one-entry fetch buffer holds {valid, word address, data}. A fetch whose word address matches a valid entry is served from the buffer: no memRequest, fetchReady the next cycle, and it does not update lastGrant. Any store whose word address matches invalidates the entry at grant. Reset clears valid.
- Without: every fetch accesses memory.

Test Plan:
1. LATENCY=1, fetch addr 0x100, memReadData=0xDEADBEEF -> memRequest at cycle 1 with memAddress=0x40 and mask 1111; fetchReady with fetchData=0xDEADBEEF at cycle 3; stall high cycles 0-2.
2. Store byte, addr 0x203, data 0x000000A5 -> memByteMask=1000, memWriteData=0xA5A5A5A5, memWriteEnable=1, dataReady 2 cycles after grant.
3. Load half, signed, addr 0x2, memReadData=0x8001xxxx -> dataReadData=0xFFFF8001; same load unsigned -> 0x00008001.
4. Fetch and data both held continuously from reset -> grants alternate data, fetch, data, ...; neither requester waits more than one foreign access.
5. Load word at addr 0x6 -> no memRequest; dataReady=1 and misaligned=1 next cycle; dataReadData=0.
6. LATENCY=3, reset asserted in READ_WAIT -> no ready pulse; all outputs 0 the cycle after; fresh fetch completes normally.
